pipelined_differencing_machine: RTL

Inverse of the pipelined adding machine: accepts a stream of 32-bit running sums and recovers the individual words (modular differences between consecutive sums). It writes each recovered word to sequential word addresses of a data memory. A two-stage pipeline sustains one word per cycle. A fixed word budget ends the run with full/done status.

---
 rtl/pipelined_differencing_machine_if.sv | 53 +++++
 rtl/pipelined_differencing_machine.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipelined_differencing_machine_if.sv
// ---------------------------------------------------------------------------
// pipelined_differencing_machine_if
//
// Bundles the running-sum input handshake, the data-memory write port and the
// run status of the pipelined differencing machine.
//
//   in_valid  : in_sum carries a running sum this cycle
//   in_sum    : 32-bit running sum (mod 2^32) of all words so far
//   in_ready  : machine accepts in_sum this cycle (~full)
//   wr_en     : memory write strobe, commits on the next rising edge
//   wr_addr   : 30-bit word address (byte address bits [31:2])
//   wr_data   : recovered word
//   full      : word budget accepted, further input ignored
//   done      : every budgeted word committed to memory
//
// Modports:
//   master : the sum producer / memory owner (drives in_valid, in_sum)
//   slave  : the differencing machine itself
// ---------------------------------------------------------------------------
interface pipelined_differencing_machine_if;

   logic        in_valid;
   logic [31:0] in_sum;
   logic        in_ready;
   logic        wr_en;
   logic [29:0] wr_addr;
   logic [31:0] wr_data;
   logic        full;
   logic        done;

   modport master (
      output in_valid,
      output in_sum,
      input  in_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  full,
      input  done
   );

   modport slave (
      input  in_valid,
      input  in_sum,
      output in_ready,
      output wr_en,
      output wr_addr,
      output wr_data,
      output full,
      output done
   );

endinterface

// File: rtl/pipelined_differencing_machine.sv
// ---------------------------------------------------------------------------
// pipelined_differencing_machine
//
// Recovers the individual words of a stream of 32-bit running sums by taking
// the modular difference between consecutive sums, and writes each recovered
// word to consecutive word addresses of a data memory. Two register stages
// sustain one word per cycle. After LIMIT words have been accepted the input
// closes (full); once the last of them has been written the run ends (done)
// and stays ended until reset.
//
// Parameters:
//   LIMIT : words accepted and written per run, 1 .. 2^30-1
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : slave view of pipelined_differencing_machine_if
//           (in_valid/in_sum/in_ready input stream,
//            wr_en/wr_addr/wr_data memory write port, full/done status)
// ---------------------------------------------------------------------------
module pipelined_differencing_machine #(
   parameter logic [29:0] LIMIT = 30'd16
) (
   input  logic                              clk,
   input  logic                              reset,
   pipelined_differencing_machine_if.slave   bus
);

   // Run state. RUN accepts input, DRAIN waits for the final write to
   // commit, DONE is terminal until reset.
   localparam logic [1:0] StRun   = 2'd0;
   localparam logic [1:0] StDrain = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]  state_q, state_d;

   // Stage 1: the accepted sum, one cycle after transfer.
   logic        s1_valid_q;
   logic [31:0] s1_sum_q;

   // Stage 2: the memory write port registers.
   logic        wr_en_q;
   logic [29:0] wr_addr_q;
   logic [31:0] wr_data_q;

   // Difference reference and counters.
   logic [31:0] prev_sum_q;
   logic [29:0] waddr_q;
   logic [29:0] acount_q;

   logic        in_ready;
   logic        xfer;
   logic        last_accept;
   logic        last_write;

   // ------------------------------------------------------------------------
   // Handshake and terminal-condition decode
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready    = (state_q == StRun);
      xfer        = bus.in_valid & in_ready;
      // acount counts transfers already taken, so this transfer is the last
      // one when acount + 1 reaches the budget.
      last_accept = xfer & ((acount_q + 30'd1) == LIMIT);
      // The write currently on the port is the final one of the run; it
      // commits on the coming edge.
      last_write  = wr_en_q & (wr_addr_q == (LIMIT - 30'd1));
   end

   // ------------------------------------------------------------------------
   // Run state machine
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (last_accept) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (last_write) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            // Unused encoding: fall back to a clean run start.
            state_d = StRun;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Pipeline, counters and state registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StRun;
         s1_valid_q <= 1'b0;
         s1_sum_q   <= 32'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 30'd0;
         wr_data_q  <= 32'd0;
         prev_sum_q <= 32'd0;
         waddr_q    <= 30'd0;
         acount_q   <= 30'd0;
      end else begin
         state_q <= state_d;

         // Stage 1 captures every edge; the sum is only sampled on transfer
         // so a bubble leaves the last accepted sum in place.
         s1_valid_q <= xfer;
         if (xfer) begin
            s1_sum_q <= bus.in_sum;
            acount_q <= acount_q + 30'd1;
         end

         // Stage 2: a bubble in stage 1 becomes a wr_en=0 cycle with the
         // address and data left as they were.
         wr_en_q <= s1_valid_q;
         if (s1_valid_q) begin
            // Modular subtraction; the borrow out is meaningless for a
            // running sum that itself wraps at 2^32.
            wr_data_q  <= s1_sum_q - prev_sum_q;
            prev_sum_q <= s1_sum_q;
            wr_addr_q  <= waddr_q;
            waddr_q    <= waddr_q + 30'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready = in_ready;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.full     = (state_q != StRun);
   assign bus.done     = (state_q == StDone);

endmodule
